// File: rtl/pattern_scheduler_pkg.sv
// Shared types for the pattern scheduler: generator field encodings, entry
// layout and the scheduler state encoding.
package pattern_scheduler_pkg;

  localparam int MODE_W  = 3;
  localparam int CONST_W = 12;
  localparam int X_W     = 2;
  localparam int Y_W     = 2;
  localparam int CFG_W   = MODE_W + CONST_W + X_W + Y_W;

  // Mode 0 is the generator's idle/blank mode; other codes pass through untouched.
  localparam logic [MODE_W-1:0] MODE_OFF = '0;

  typedef enum logic [1:0] {
    VAL_RAMP  = 2'b00,
    VAL_CONST = 2'b01,
    VAL_ONES  = 2'b10,
    VAL_OUT   = 2'b11
  } val_sel_e;

  localparam logic SEL_BINARY = 1'b0;
  localparam logic SEL_GRAY   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [MODE_W-1:0]  mode;
    logic [CONST_W-1:0] const_val;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
  } cfg_t;

endpackage

// File: rtl/pattern_playlist_ram.sv
// Playlist storage: register array with one synchronous write port and one
// combinational, write-first read port; cleared by the asynchronous reset.
module pattern_playlist_ram #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int W     = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A same-cycle write to the address being loaded must win.
  assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];

endmodule

// File: rtl/pattern_scheduler.sv
// Frame-level playlist sequencer in front of the pattern generator.
// Define PATSCHED_LOOP_EN to honour the loop input; otherwise it is ignored.
module pattern_scheduler
  import pattern_scheduler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_sync,
  input  logic             sync,
  input  logic             cfg_wr,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [2:0]       cfg_mode,
  input  logic [11:0]      cfg_const,
  input  logic [1:0]       cfg_x,
  input  logic [1:0]       cfg_y,
  input  logic [REP_W-1:0] cfg_rep,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic             pg_f_sync,
  output logic             pg_sync,
  output logic [2:0]       Mode,
  output logic [11:0]      constVal,
  output logic [1:0]       X,
  output logic [1:0]       Y,
  output logic [IDX_W-1:0] entry_idx,
  output logic             running,
  output logic             done
);

  localparam int ENTRY_W = CFG_W + REP_W;

  sched_state_e     state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [IDX_W-1:0] idx_q, idx_d, rd_addr;
  logic [REP_W-1:0] rep_q, rep_d, frm_cnt_q, frm_cnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic             done_q, done_d;
  logic             pg_f_sync_q, pg_sync_q;
  logic             load;
  logic             loop_en;
  logic [ENTRY_W-1:0] wr_data, rd_data;
  logic [REP_W:0]   rep_eff, frm_next;

`ifdef PATSCHED_LOOP_EN
  assign loop_en = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_en     = 1'b0;
`endif

  assign wr_data = {cfg_mode, cfg_const, cfg_x, cfg_y, cfg_rep};

  // The only entries ever loaded are entry 0 and the successor of the active one.
  assign rd_addr = ((state_q == ST_RUN) && (idx_q != last_idx)) ? idx_q + 1'b1 : '0;

  pattern_playlist_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .W     (ENTRY_W)
  ) u_playlist (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_wr),
    .wr_addr (cfg_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rep_eff  = (rep_q == '0) ? (REP_W+1)'(1) : {1'b0, rep_q};
  assign frm_next = {1'b0, frm_cnt_q} + 1'b1;

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    frm_cnt_d   = frm_cnt_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (f_sync) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (f_sync) begin
          if (stop_pend_q) begin
            state_d     = ST_IDLE;
            cfg_d       = '0;
            idx_d       = '0;
            rep_d       = '0;
            frm_cnt_d   = '0;
            stop_pend_d = 1'b0;
          end else if (frm_next < rep_eff) begin
            frm_cnt_d = (&frm_cnt_q) ? frm_cnt_q : frm_cnt_q + 1'b1;
          end else if ((idx_q != last_idx) || loop_en) begin
            load = 1'b1;
          end else begin
            done_d      = 1'b1;
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      cfg_d     = rd_data[ENTRY_W-1:REP_W];
      rep_d     = rd_data[REP_W-1:0];
      idx_d     = rd_addr;
      frm_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      idx_q       <= '0;
      rep_q       <= '0;
      frm_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      pg_f_sync_q <= 1'b0;
      pg_sync_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      frm_cnt_q   <= frm_cnt_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      pg_f_sync_q <= f_sync;
      pg_sync_q   <= sync;
    end
  end

  assign pg_f_sync = pg_f_sync_q;
  assign pg_sync   = pg_sync_q;
  assign Mode      = cfg_q.mode;
  assign constVal  = cfg_q.const_val;
  assign X         = cfg_q.x;
  assign Y         = cfg_q.y;
  assign entry_idx = idx_q;
  assign running   = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Scoreboard bench for pattern_scheduler: a playlist model predicts the
// generator configuration for every frame start; a monitor checks each pg_f_sync.
module tb_pattern_scheduler;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             f_sync, sync, cfg_wr, loop, start, stop;
  logic [IDX_W-1:0] cfg_addr, last_idx;
  logic [2:0]       cfg_mode;
  logic [11:0]      cfg_const;
  logic [1:0]       cfg_x, cfg_y;
  logic [REP_W-1:0] cfg_rep;
  logic             pg_f_sync, pg_sync, running, done;
  logic [2:0]       Mode;
  logic [11:0]      constVal;
  logic [1:0]       X, Y;
  logic [IDX_W-1:0] entry_idx;

  always #8 clk = ~clk;

  pattern_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst_n(rst_n), .f_sync(f_sync), .sync(sync),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_const(cfg_const), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_rep(cfg_rep),
    .last_idx(last_idx), .loop(loop), .start(start), .stop(stop),
    .pg_f_sync(pg_f_sync), .pg_sync(pg_sync), .Mode(Mode), .constVal(constVal),
    .X(X), .Y(Y), .entry_idx(entry_idx), .running(running), .done(done)
  );

  typedef struct packed {
    logic        fs;
    logic        sy;
    logic        wr;
    logic [2:0]  addr;
    logic [2:0]  mode;
    logic [11:0] cv;
    logic [1:0]  x;
    logic [1:0]  y;
    logic [3:0]  rep;
    logic        st;
    logic        sp;
  } stim_t;

  typedef struct packed {
    logic [2:0]  mode;
    logic [11:0] cv;
    logic [1:0]  x;
    logic [1:0]  y;
    logic [2:0]  idx;
    logic        run;
    logic        dn;
    logic        psync;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   vectors = 0;
  int   miscompares = 0;

  // Playlist model: what is playing and how many frames of it have been shown.
  logic [22:0] pl [DEPTH];
  int          mState;   // 0 = idle, 1 = waiting for first frame, 2 = playing
  int          mIdx, mFramesShown, mRepLoaded;
  logic [18:0] mCfg;
  bit          mStopAsked;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < DEPTH; i++) pl[i] = '0;
    mState = 0; mIdx = 0; mFramesShown = 0; mRepLoaded = 0; mCfg = '0; mStopAsked = 0;
    expQ.delete();
  endtask

  task automatic playEntry(input int i);
    mCfg         = pl[i][22:4];
    mRepLoaded   = int'(pl[i][3:0]);
    mIdx         = i;
    mFramesShown = 1;
  endtask

  function automatic bit loopHonoured();
`ifdef PATSCHED_LOOP_EN
    return loop;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of inputs, predict the frame-start result, wait a cycle.
  task automatic applyStimulus(input stim_t s);
    bit endPulse = 0;
    bit stopDue;
    int framesWanted;
    f_sync = s.fs; sync = s.sy; cfg_wr = s.wr; cfg_addr = s.addr;
    cfg_mode = s.mode; cfg_const = s.cv; cfg_x = s.x; cfg_y = s.y; cfg_rep = s.rep;
    start = s.st; stop = s.sp;

    if (s.wr) pl[s.addr] = {s.mode, s.cv, s.x, s.y, s.rep};
    framesWanted = (mRepLoaded == 0) ? 1 : mRepLoaded;
    stopDue = mStopAsked;
    if (mState == 0) begin
      if (s.st && !s.sp) mState = 1;
    end else if (mState == 1) begin
      if (s.sp) mState = 0;
      else if (s.fs) begin playEntry(0); mState = 2; end
    end else begin
      if (s.sp) mStopAsked = 1;
      if (s.fs) begin
        if (stopDue) begin
          mCfg = '0; mIdx = 0; mState = 0; mStopAsked = 0;
        end else if (mFramesShown < framesWanted) begin
          mFramesShown++;
        end else if (mIdx != int'(last_idx)) begin
          playEntry(mIdx + 1);
        end else if (loopHonoured()) begin
          playEntry(0);
        end else begin
          endPulse = 1; mState = 0; mStopAsked = 0;
        end
      end
    end
    if (s.fs) expQ.push_back({mCfg, 3'(mIdx), (mState != 0), endPulse, s.sy});
    @(negedge clk);
  endtask

  function automatic stim_t quiet();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t frame();
    stim_t s = '0;
    s.fs = 1'b1; s.sy = 1'b1;
    return s;
  endfunction

  function automatic stim_t wrEntry(input int a, input int m, input int cv, input int x, input int y, input int rep);
    stim_t s = '0;
    s.wr = 1'b1; s.addr = 3'(a); s.mode = 3'(m); s.cv = 12'(cv);
    s.x = 2'(x); s.y = 2'(y); s.rep = 4'(rep);
    return s;
  endfunction

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(quiet());
  endtask

  task automatic frameThenIdle();
    applyStimulus(frame());
    idleCycles(3);
  endtask

  task automatic pulseStart();
    stim_t s = '0;
    s.st = 1'b1;
    applyStimulus(s);
  endtask

  task automatic pulseStop();
    stim_t s = '0;
    s.sp = 1'b1;
    applyStimulus(s);
  endtask

  always @(negedge clk) begin
    if (rst_n && pg_f_sync) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_frame", 32'd1, 32'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("Mode", 32'(Mode), 32'(monE.mode));
        checkOutput("constVal", 32'(constVal), 32'(monE.cv));
        checkOutput("X", 32'(X), 32'(monE.x));
        checkOutput("Y", 32'(Y), 32'(monE.y));
        checkOutput("entry_idx", 32'(entry_idx), 32'(monE.idx));
        checkOutput("running", 32'(running), 32'(monE.run));
        checkOutput("done", 32'(done), 32'(monE.dn));
        checkOutput("pg_sync", 32'(pg_sync), 32'(monE.psync));
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_Mode"}, 32'(Mode), 32'd0);
    checkOutput({tag, "_constVal"}, 32'(constVal), 32'd0);
    checkOutput({tag, "_XY"}, 32'({X, Y}), 32'd0);
    checkOutput({tag, "_entry_idx"}, 32'(entry_idx), 32'd0);
    checkOutput({tag, "_running"}, 32'(running), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_pg_f_sync"}, 32'(pg_f_sync), 32'd0);
  endtask

  initial begin
    stim_t s;
    rst_n = 1'b0;
    f_sync = 0; sync = 0; cfg_wr = 0; cfg_addr = '0; cfg_mode = '0; cfg_const = '0;
    cfg_x = '0; cfg_y = '0; cfg_rep = '0; last_idx = '0; loop = 0; start = 0; stop = 0;
    resetModel();
    #20;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single entry, one frame, then done.
    applyStimulus(wrEntry(0, 3, 12'hABC, 1, 2, 1));
    last_idx = 3'd0;
    pulseStart();
    frameThenIdle();
    frameThenIdle();
    frameThenIdle();

    // Repeat counts: 2 frames of entry 0, 1 frame of entry 1 (rep 0).
    applyStimulus(wrEntry(0, 1, 12'h111, 0, 1, 2));
    applyStimulus(wrEntry(1, 2, 12'h222, 2, 3, 0));
    last_idx = 3'd1;
    pulseStart();
    for (int i = 0; i < 4; i++) frameThenIdle();

    // Loop across entries 0 and 1.
    applyStimulus(wrEntry(0, 4, 12'h0F0, 1, 1, 1));
    applyStimulus(wrEntry(1, 5, 12'hF0F, 2, 2, 1));
    loop = 1'b1;
    pulseStart();
    for (int i = 0; i < 4; i++) frameThenIdle();
    pulseStop();
    frameThenIdle();
    loop = 1'b0;

    // Stop mid-frame, then start+stop together from idle.
    pulseStart();
    frameThenIdle();
    pulseStop();
    idleCycles(2);
    frameThenIdle();
    s = quiet(); s.st = 1'b1; s.sp = 1'b1;
    applyStimulus(s);
    frameThenIdle();

    // Write/load collision on entry 1.
    applyStimulus(wrEntry(1, 6, 12'h123, 0, 0, 1));
    applyStimulus(wrEntry(2, 7, 12'h777, 3, 3, 1));
    last_idx = 3'd2;
    pulseStart();
    frameThenIdle();
    s = wrEntry(1, 5, 12'h555, 3, 0, 1); s.fs = 1'b1; s.sy = 1'b1;
    applyStimulus(s);
    idleCycles(3);
    frameThenIdle();
    frameThenIdle();

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      s = quiet();
      s.fs = ($urandom_range(0, 5) == 0);
      s.sy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        s.wr = 1'b1; s.addr = 3'($urandom); s.mode = 3'($urandom); s.cv = 12'($urandom);
        s.x = 2'($urandom); s.y = 2'($urandom); s.rep = 4'($urandom_range(0, 3));
      end
      s.st = ($urandom_range(0, 7) == 0);
      s.sp = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) last_idx = 3'($urandom);
      if ($urandom_range(0, 49) == 0) loop = 1'($urandom);
      applyStimulus(s);
    end

    // Asynchronous reset in the middle of playback.
    loop = 1'b0;
    last_idx = 3'd1;
    applyStimulus(wrEntry(0, 3, 12'hDEF, 2, 1, 3));
    pulseStart();
    frameThenIdle();
    #3 rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    resetModel();
    #5 rst_n = 1'b1;
    @(negedge clk);
    frameThenIdle();
    pulseStart();
    frameThenIdle();
    idleCycles(2);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pattern_scheduler.md
Name: pattern_scheduler

Overview:
- Frame-level sequencer placed in front of the pattern generator datapath.
- Holds a programmable playlist of DEPTH entries. Each entry is {Mode, constVal, X, Y, repeat}.
- Drives the generator's configuration inputs and changes them only on frame boundaries (f_sync), so configuration never changes mid-frame.
- Delays f_sync/sync by one cycle so the generator sees the new configuration aligned with its own f_sync.

Parameters:
- DEPTH, 8, number of playlist entries (power of 2).
- IDX_W, 3, log2(DEPTH).
- REP_W, 4, width of the per-entry frame repeat count.

Ports:
- clk  in  1  master clock (16 ns)
- rst_n  in  1  asynchronous active-low reset
- f_sync  in  1  first-sync (frame start) pulse from the timing source
- sync  in  1  line sync pulse from the timing source
- cfg_wr  in  1  playlist write strobe (one write per cycle)
- cfg_addr  in  IDX_W  entry index to write
- cfg_mode  in  3  Mode field
- cfg_const  in  12  constVal field
- cfg_x  in  2  X field
- cfg_y  in  2  Y field
- cfg_rep  in  REP_W  frames to play the entry; 0 is treated as 1
- last_idx  in  IDX_W  index of the last playlist entry
- loop  in  1  wrap to entry 0 after last_idx (see Optional Feature)
- start  in  1  start pulse
- stop  in  1  stop request pulse
- pg_f_sync  out  1  f_sync delayed 1 cycle, to the generator
- pg_sync  out  1  sync delayed 1 cycle, to the generator
- Mode  out  3  to the generator
- constVal  out  12  to the generator
- X  out  2  to the generator
- Y  out  2  to the generator
- entry_idx  out  IDX_W  active entry index
- running  out  1  high in ARMED or RUN
- done  out  1  one-cycle pulse at the end of the playlist

Behaviour:
- Reset values: all outputs 0, state IDLE, playlist contents 0, stop_pend 0.
- pg_f_sync and pg_sync: registered copies of f_sync and sync. They run in every state, including IDLE.
- Configuration outputs (Mode, constVal, X, Y, entry_idx) are registers. They are updated only in a cycle where f_sync=1, so they become valid in the same cycle pg_f_sync=1.
- States: IDLE, ARMED, RUN.
- IDLE:
  - start=1 and stop=0 -> ARMED; running=1.
  - Outputs hold their last values.
- ARMED:
  - stop=1 -> IDLE immediately.
  - f_sync=1 -> load entry 0; frm_cnt=0; -> RUN.
- RUN: on each f_sync:
  - If stop_pend=1 -> IDLE. Config outputs go to 0 (Mode=0, constVal=0, X=0, Y=0), entry_idx=0, stop_pend cleared.
  - Else if frm_cnt+1 < max(rep,1) -> frm_cnt++, config unchanged.
  - Else if entry_idx != last_idx -> load entry_idx+1; frm_cnt=0.
  - Else if loop=1 -> load entry 0; frm_cnt=0.
  - Else -> done=1 for one cycle; -> IDLE; outputs hold the last entry.
- Load definition: all config outputs take the entry fields and entry_idx takes the index, together in one registered cycle.
- stop in RUN sets stop_pend; it takes effect at the next f_sync. stop in IDLE is ignored.
- start while ARMED or RUN is ignored.
- start and stop in the same cycle: stop wins.
- cfg_wr is accepted in every state.
  - Write and load of the same address in the same cycle: the loaded value is the new write data (write-first bypass).
  - A write to the active entry does not change the outputs until that entry is next loaded.
- last_idx and loop are sampled at each f_sync decision and may change at any time.
- frm_cnt is REP_W bits wide and saturates; no wrap is possible because it resets on every load.
- Reset asserted mid-operation: immediate return to the reset values. Playlist contents are cleared.
- Latency: f_sync to new config is 1 cycle; stop to IDLE is up to one frame.

Optional Feature:
- Macro: PATSCHED_LOOP_EN.
- Defined: the loop input is honoured as described above.
- Undefined: the loop port remains but is ignored and treated as 0. The playlist always ends with done after last_idx.

Decomposition:
- Shared package holds:
  - Mode encodings.
  - ValSel encodings {Ramp=2'b00, Const=2'b01, Ones=2'b10, Out=2'b11}.
  - Binary/Gray selector values.
  - Scheduler state encoding {IDLE, ARMED, RUN}.
  - Entry field widths (3/12/2/2).
- One natural sub-module: pattern_playlist_ram.
  - DEPTH x (19+REP_W) register array.
  - One synchronous write port and one combinational read port.
  - Write-first bypass.
  - Asynchronous clear on rst_n.

Test Plan:
- Reset check: write entry 0 {Mode=3, const=0xABC, X=1, Y=2, rep=1}, last_idx=0, start, then f_sync -> 1 cycle later Mode=3, constVal=0xABC, X=1, Y=2, pg_f_sync=1. Next f_sync -> done pulse, state IDLE, outputs hold.
- Repeat counts: entries 0 {rep=2} and 1 {rep=0} -> entry 0 lasts 2 frames, entry 1 lasts 1 frame, then done. entry_idx sequence is 0,0,1.
- Loop: last_idx=1, loop=1, both entries rep=1 -> entry_idx sequence 0,1,0,1 across 4 f_syncs; no done. With the macro undefined -> done after entry 1.
- Stop: stop mid-frame in RUN -> config unchanged until the next f_sync, then all config outputs 0 and running=0. start and stop in the same cycle from IDLE -> stays IDLE.
- Write/load collision: cfg_wr to address 1 {const=0x555} in the same cycle that f_sync loads entry 1 -> constVal=0x555 the next cycle.
- Async reset mid-RUN: assert rst_n low for a non-clock-aligned pulse -> outputs go to 0 immediately. After release, f_sync produces no load until start.
